// File: rtl/turnstile_pkg.sv
// Shared types and helpers for the turnstile lane arbiter.
// The timer width is sized from the longest wait the FSM ever has to count.
package turnstile_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COIN    = 3'd1,
    WAIT_UL = 3'd2,
    OPEN    = 3'd3,
    START   = 3'd4,
    WAIT_LK = 3'd5,
    ERR     = 3'd6
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int tmr_width(input int pass_to, input int hs_to);
    return $clog2(max_int(pass_to, hs_to) + 1);
  endfunction

endpackage

// File: rtl/turnstile_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Returns both a one-hot select and its index.
module rr_pick
  import turnstile_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic [PTR_W-1:0] sel_idx,
  output logic             valid
);

  // Two passes: lanes from ptr upward first, then the wrapped lanes below ptr.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[k] && (PTR_W'(k) >= ptr)) begin
        valid   = 1'b1;
        sel[k]  = 1'b1;
        sel_idx = PTR_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!valid && req[k] && (PTR_W'(k) < ptr)) begin
        valid   = 1'b1;
        sel[k]  = 1'b1;
        sel_idx = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/turnstile_arb.sv
// Round-robin scheduler sharing one fsm_ctrl turnstile among several entry lanes,
// with per-lane banked coin credits and a timed pass window per grant.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no lane in service; pick next lane with credit, spend one
//  COIN    | coin pulse to fsm_ctrl
//  WAIT_UL | wait for fsm_ctrl unlock (handshake timeout -> ERR)
//  OPEN    | gate open for selected lane until pass or pass timeout
//  START   | start pulse to fsm_ctrl (relock)
//  WAIT_LK | wait for fsm_ctrl lock, then advance RR pointer
//  ERR     | handshake failure; sticky until reset, credits keep banking
module turnstile_arb
  import turnstile_pkg::*;
#(
  parameter int N_LANE   = 4,
  parameter int CREDIT_W = 4,
  parameter int PASS_TO  = 16,
  parameter int HS_TO    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LANE-1:0] coin_i,
  input  logic [N_LANE-1:0] pass_i,
  input  logic              lock_i,
  input  logic              unlock_i,
  output logic              coin_o,
  output logic              start_o,
  output logic [N_LANE-1:0] grant_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [N_LANE-1:0] drop_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(N_LANE);
  localparam int TMR_W = tmr_width(PASS_TO, HS_TO);
  localparam logic [CREDIT_W-1:0] CRED_MAX  = '1;
  localparam logic [TMR_W-1:0]    PASS_LOAD = TMR_W'(PASS_TO - 1);
  localparam logic [TMR_W-1:0]    HS_LOAD   = TMR_W'(HS_TO - 1);

  state_t state, state_nx;

  logic [CREDIT_W-1:0] credit  [N_LANE];
  logic [CREDIT_W-1:0] cred_nx [N_LANE];
  logic [N_LANE-1:0]   req, drop_nx, dec_vec, pick_oh, sel_oh;
  logic [PTR_W-1:0]    pick_idx, sel, rr_ptr;
  logic                pick_vld, dec_en, pass_sel, tmr_tc;
  logic [TMR_W-1:0]    tmr;

  logic              coin_d, start_d, busy_d, timeout_d, err_d;
  logic [N_LANE-1:0] grant_d;

  always_comb begin
    for (int k = 0; k < N_LANE; k++) begin
      req[k] = (credit[k] != '0);
    end
  end

  rr_pick #(
    .N     (N_LANE),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .sel     (pick_oh),
    .sel_idx (pick_idx),
    .valid   (pick_vld)
  );

  assign dec_en   = (state == IDLE) && pick_vld;
  assign dec_vec  = dec_en ? pick_oh : '0;
  assign pass_sel = pass_i[sel];
  assign tmr_tc   = (tmr == '0);
  assign sel_oh   = N_LANE'(1) << sel;

  // A coin and a spend on the same lane cancel: no change, no drop.
  always_comb begin
    for (int k = 0; k < N_LANE; k++) begin
      cred_nx[k] = credit[k];
      drop_nx[k] = 1'b0;
      if (coin_i[k] && !dec_vec[k]) begin
        if (credit[k] == CRED_MAX) drop_nx[k] = 1'b1;
        else                       cred_nx[k] = credit[k] + CREDIT_W'(1);
      end else if (!coin_i[k] && dec_vec[k]) begin
        cred_nx[k] = credit[k] - CREDIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LANE; k++) credit[k] <= '0;
    end else begin
      for (int k = 0; k < N_LANE; k++) credit[k] <= cred_nx[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      if (dec_en) sel <= pick_idx;
      if ((state == WAIT_LK) && lock_i)
        rr_ptr <= (sel == PTR_W'(N_LANE - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

  // Down-counter reloaded on every state change; terminal count = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state_nx != state) begin
      case (state_nx)
        WAIT_UL, WAIT_LK: tmr <= HS_LOAD;
        OPEN:             tmr <= PASS_LOAD;
        default:          tmr <= '0;
      endcase
    end else if (!tmr_tc) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = COIN;
      COIN:    state_nx = WAIT_UL;
      WAIT_UL: begin
        if (unlock_i)    state_nx = OPEN;
        else if (tmr_tc) state_nx = ERR;
      end
      OPEN:    if (pass_sel || tmr_tc) state_nx = START;
      START:   state_nx = WAIT_LK;
      WAIT_LK: begin
        if (lock_i)      state_nx = IDLE;
        else if (tmr_tc) state_nx = ERR;
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state.
  always_comb begin
    coin_d    = (state_nx == COIN);
    start_d   = (state_nx == START);
    busy_d    = (state_nx != IDLE);
    err_d     = (state_nx == ERR);
    grant_d   = (state_nx == OPEN) ? sel_oh : '0;
    timeout_d = (state == OPEN) && (state_nx == START) && !pass_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_o    <= 1'b0;
      start_o   <= 1'b0;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
      drop_o    <= '0;
      err_o     <= 1'b0;
    end else begin
      coin_o    <= coin_d;
      start_o   <= start_d;
      grant_o   <= grant_d;
      busy_o    <= busy_d;
      timeout_o <= timeout_d;
      drop_o    <= drop_nx;
      err_o     <= err_d;
    end
  end

endmodule

// File: tb/tb_turnstile_arb.sv
// Self-checking bench for turnstile_arb: fsm_ctrl stub (Moore or Mealy), transaction-level
// reference model feeding a scoreboard, plus directed latency, error and reset checks.
module tb_turnstile_arb;

  localparam int N       = 4;
  localparam int PASS_TO = 16;
  localparam int HS_TO   = 8;
  localparam int CMAX    = 15;
  localparam int NEVER   = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] coin_i = '0;
  logic [N-1:0] pass_i = '0;
  logic         lock_i, unlock_i;
  logic         coin_o, start_o, busy_o, timeout_o, err_o;
  logic [N-1:0] grant_o, drop_o;

  always #5 clk = ~clk;

  turnstile_arb #(.N_LANE(N), .CREDIT_W(4), .PASS_TO(PASS_TO), .HS_TO(HS_TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_i    (coin_i),
    .pass_i    (pass_i),
    .lock_i    (lock_i),
    .unlock_i  (unlock_i),
    .coin_o    (coin_o),
    .start_o   (start_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .drop_o    (drop_o),
    .err_o     (err_o)
  );

  // fsm_ctrl stand-in: coin unlocks, start relocks; Mealy mode reacts in the same cycle.
  logic mealy = 1'b0;
  logic hold_ul = 1'b0;
  logic unl_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       unl_q <= 1'b0;
    else if (coin_o)  unl_q <= 1'b1;
    else if (start_o) unl_q <= 1'b0;
  end
  assign unlock_i = !hold_ul && (mealy ? ((unl_q || coin_o) && !start_o) : unl_q);
  assign lock_i   = mealy ? ((!unl_q || start_o) && !coin_o) : !unl_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each grant occupies a fixed number of cycles determined by the
  // pass delay the bench chose for it; between grants, credits follow coin arithmetic.
  typedef struct {
    int lane;
    bit to;
  } exp_t;

  exp_t   exp_q[$];
  int     pdq[$];
  int     m_cred[N];
  int     m_ptr, m_wait, m_dec, m_d, m_len;
  logic [N-1:0] m_drop;
  bit     model_en = 1'b0;
  int     d_mode = 0;

  function automatic bit model_idle();
    for (int k = 0; k < N; k++) if (m_cred[k] != 0) return 1'b0;
    return (m_wait == 0) && (exp_q.size() == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n || !model_en) begin
      for (int k = 0; k < N; k++) m_cred[k] = 0;
      m_ptr = 0; m_wait = 0; m_drop = '0;
      exp_q.delete(); pdq.delete();
    end else begin
      m_dec = -1;
      if (m_wait > 0) begin
        m_wait--;
      end else begin
        for (int i = 0; i < N; i++)
          if (m_dec < 0 && m_cred[(m_ptr + i) % N] > 0) m_dec = (m_ptr + i) % N;
        if (m_dec >= 0) begin
          if (d_mode >= 0) m_d = d_mode;
          else if ($urandom_range(0, 7) == 0) m_d = $urandom_range(14, 18);
          else m_d = $urandom_range(0, 4);
          m_len = (m_d + 1 < PASS_TO) ? m_d + 1 : PASS_TO;
          exp_q.push_back('{lane: m_dec, to: (m_d >= PASS_TO)});
          pdq.push_back(m_d);
          m_wait = 4 + m_len;
          m_ptr = (m_dec + 1) % N;
        end
      end
      for (int k = 0; k < N; k++) begin
        m_drop[k] = 1'b0;
        if (coin_i[k] && k != m_dec) begin
          if (m_cred[k] == CMAX) m_drop[k] = 1'b1;
          else m_cred[k]++;
        end else if (!coin_i[k] && k == m_dec) begin
          m_cred[k]--;
        end
      end
    end
  end

  // Pass-sensor driver: pulses the granted lane d cycles into the window; noise on other lanes.
  bit noise_en = 1'b0;
  bit pd_active = 1'b0;
  int pd_cnt, pd_d;
  logic [N-1:0] pass_man;
  always @(negedge clk) begin
    pass_man = '0;
    if (!rst_n) begin
      pd_active = 1'b0;
    end else begin
      if (grant_o != '0 && !pd_active) begin
        pd_active = 1'b1;
        pd_cnt = 0;
        pd_d = (pdq.size() != 0) ? pdq.pop_front() : NEVER;
      end
      if (pd_active) begin
        if (grant_o == '0) pd_active = 1'b0;
        else begin
          if (pd_cnt == pd_d) pass_man = grant_o;
          pd_cnt++;
        end
      end
    end
    pass_i = pass_man | (noise_en ? (N'($urandom) & ~grant_o) : '0);
  end

  // Scoreboard monitor.
  logic [N-1:0] prev_grant = '0;
  exp_t mon_e;
  bit   cur_to = 1'b0;
  always @(negedge clk) begin
    if (rst_n && model_en) begin
      if (grant_o != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) chk("unexpected_grant", grant_o, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("grant_lane", grant_o, 1 << mon_e.lane);
          cur_to = mon_e.to;
        end
      end
      if (start_o) chk("timeout_flag", timeout_o, cur_to);
      else if (timeout_o) chk("timeout_without_start", timeout_o, 0);
      chk("drop", drop_o, m_drop);
    end
    prev_grant = grant_o;
  end

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while (n < budget && !(model_idle() && busy_o == 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, cnt;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_coin", coin_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;
    model_en = 1'b1;
    @(negedge clk);

    // single coin on lane 2, immediate pass, Moore stub
    d_mode = 0;
    coin_i = 4'b0100;
    @(negedge clk); coin_i = '0;
    chk("coin_early", coin_o, 0);
    @(negedge clk);
    chk("coin_latency", coin_o, 1);
    repeat (2) @(negedge clk);
    chk("grant_lane2", grant_o, 4'b0100);
    repeat (2) @(negedge clk);
    chk("seq_busy_last", busy_o, 1);
    @(negedge clk);
    chk("seq_len_6", busy_o, 0);
    drain(50, "lane2");

    // all lanes at once: RR order 3 (ptr after lane 2), 0, 1, 2
    coin_i = 4'b1111;
    @(negedge clk); coin_i = '0;
    drain(200, "all_lanes");

    // saturation on lane 1
    for (int i = 0; i < 20; i++) begin
      coin_i = 4'b0010;
      @(negedge clk);
    end
    coin_i = '0;
    drain(1000, "saturate");

    // pass window timeout on lane 0
    d_mode = NEVER;
    coin_i = 4'b0001;
    @(negedge clk); coin_i = '0;
    n = 0;
    while (n < 20 && grant_o == '0) begin @(negedge clk); n++; end
    cnt = 0;
    while (cnt < 40 && grant_o != '0) begin @(negedge clk); cnt++; end
    chk("open_len", cnt, PASS_TO);
    drain(100, "timeout");
    repeat (5) @(negedge clk);
    chk("idle_after_timeout", busy_o, 0);

    // Mealy stub with randomized traffic and pass delays
    mealy = 1'b1;
    d_mode = -1;
    noise_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      coin_i = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      @(negedge clk);
    end
    coin_i = '0;
    drain(5000, "random");
    noise_en = 1'b0;

    // handshake timeout -> sticky error
    model_en = 1'b0;
    mealy = 1'b0;
    hold_ul = 1'b1;
    coin_i = 4'b1000;
    @(negedge clk); coin_i = '0;
    repeat (9) @(negedge clk);
    chk("err_not_yet", err_o, 0);
    @(negedge clk);
    chk("err_set", err_o, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      coin_i = N'($urandom);
      @(negedge clk);
      if (!err_o || coin_o || start_o || grant_o != '0) cnt++;
    end
    coin_i = '0;
    chk("err_sticky", cnt, 0);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", err_o, 0);
    hold_ul = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // reset while gate is open: grant drops asynchronously, banked credit lost
    coin_i = 4'b0001;
    repeat (2) @(negedge clk);
    coin_i = '0;
    n = 0;
    while (n < 20 && grant_o == '0) begin @(negedge clk); n++; end
    chk("grant_before_rst", grant_o, 4'b0001);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant_async", grant_o, 0);
    chk("rst_busy_async", busy_o, 0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o || coin_o) cnt++;
    end
    chk("credits_lost", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
